// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// gshare_predictor : gshare branch direction predictor with PHT reset sweep
// Revision 1.0
// ============================================================================
module gshare_predictor #(
  parameter int HIST_BITS = 12,
  parameter int CTR_BITS  = 2,
  parameter int PC_LSB    = 2,
  parameter int INIT_CTR  = (1 << (CTR_BITS - 1)) - 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic [31:0]          Instr_input,
  input  logic [31:0]          Instr_addr_input,
  output logic                 Taken,
  output logic                 Pred_valid,
  output logic [HIST_BITS-1:0] Pred_index,
  output logic                 Ready,
  input  logic                 Update_valid,
  input  logic [HIST_BITS-1:0] Update_index,
  input  logic                 Update_taken,
  input  logic                 Update_mispredict
);

  localparam int                   DEPTH        = 1 << HIST_BITS;
  localparam logic [CTR_BITS-1:0]  c_INIT_CTR   = CTR_BITS'(INIT_CTR);
  localparam logic [HIST_BITS-1:0] c_SWEEP_LAST = '1;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t               r_state;
  logic [HIST_BITS-1:0] r_sweep_cnt;
  logic [HIST_BITS-1:0] r_ghr_spec;
  logic [HIST_BITS-1:0] r_ghr_arch;
  logic                 r_taken;
  logic                 r_pred_valid;
  logic [HIST_BITS-1:0] r_pred_index;
  logic                 r_ready;
  logic [CTR_BITS-1:0]  r_pht [DEPTH];

  logic [5:0]           w_opcode;
  logic [4:0]           w_rt;
  logic                 w_is_branch;
  logic [HIST_BITS-1:0] w_index;
  logic [CTR_BITS-1:0]  w_lookup_ctr;
  logic                 w_restore;
  logic                 w_predict;
  logic                 w_pred_taken;
  logic [HIST_BITS-1:0] w_ghr_arch_nxt;
  logic [CTR_BITS-1:0]  w_upd_ctr;
  logic [CTR_BITS-1:0]  w_upd_ctr_nxt;
  logic                 w_unused;

  assign w_opcode    = Instr_input[31:26];
  assign w_rt        = Instr_input[20:16];
  // REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL, or BEQ/BNE/BLEZ/BGTZ
  assign w_is_branch = ((w_opcode == 6'b000001) &&
                        ((w_rt == 5'b00000) || (w_rt == 5'b00001) ||
                         (w_rt == 5'b10000) || (w_rt == 5'b10001))) ||
                       (w_opcode[5:2] == 4'b0001);

  assign w_index        = r_ghr_spec ^ Instr_addr_input[PC_LSB +: HIST_BITS];
  assign w_lookup_ctr   = r_pht[w_index];
  assign w_restore      = (Update_valid & Update_mispredict) | FLUSH;
  assign w_predict      = w_is_branch & ~w_restore;
  assign w_pred_taken   = w_predict & w_lookup_ctr[CTR_BITS-1];
  assign w_ghr_arch_nxt = Update_valid ? {r_ghr_arch[HIST_BITS-2:0], Update_taken}
                                       : r_ghr_arch;
  assign w_upd_ctr      = r_pht[Update_index];
  assign w_unused       = &{1'b0, Instr_input[25:21], Instr_input[15:0], Instr_addr_input};

  always_comb begin
    w_upd_ctr_nxt = w_upd_ctr;
    if (Update_taken && !(&w_upd_ctr)) begin
      w_upd_ctr_nxt = w_upd_ctr + 1'b1;
    end else if (!Update_taken && (|w_upd_ctr)) begin
      w_upd_ctr_nxt = w_upd_ctr - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= SWEEP;
      r_sweep_cnt  <= '0;
      r_ghr_spec   <= '0;
      r_ghr_arch   <= '0;
      r_taken      <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_index <= '0;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        SWEEP: begin
          r_taken      <= 1'b0;
          r_pred_valid <= 1'b0;
          r_pred_index <= '0;
          r_sweep_cnt  <= r_sweep_cnt + 1'b1;
          if (r_sweep_cnt == c_SWEEP_LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_taken      <= w_pred_taken;
          r_pred_valid <= w_predict;
          r_pred_index <= w_index;
          r_ghr_arch   <= w_ghr_arch_nxt;
          // restored history already includes the resolving branch's outcome
          if (w_restore) begin
            r_ghr_spec <= w_ghr_arch_nxt;
          end else if (w_predict) begin
            r_ghr_spec <= {r_ghr_spec[HIST_BITS-2:0], w_pred_taken};
          end
        end
      endcase
    end
  end

  // The table itself carries no reset; the sweep initialises it instead.
  always_ff @(posedge CLK) begin
    if (r_state == SWEEP) begin
      r_pht[r_sweep_cnt] <= c_INIT_CTR;
    end else if (Update_valid) begin
      r_pht[Update_index] <= w_upd_ctr_nxt;
    end
  end

  assign Taken      = r_taken;
  assign Pred_valid = r_pred_valid;
  assign Pred_index = r_pred_index;
  assign Ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// tb_gshare_predictor : scoreboard bench for gshare_predictor with HIST_BITS=4,
// checked against an arithmetic reference model of the predictor.
module tb_gshare_predictor;

  localparam int HB     = 4;
  localparam int DEPTH  = 16;
  localparam int CMAX   = 3;
  localparam int THRESH = 2;
  localparam int INIT   = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] Instr_input = '0;
  logic [31:0] Instr_addr_input = '0;
  logic        Taken;
  logic        Pred_valid;
  logic [HB-1:0] Pred_index;
  logic        Ready;
  logic        Update_valid = 1'b0;
  logic [HB-1:0] Update_index = '0;
  logic        Update_taken = 1'b0;
  logic        Update_mispredict = 1'b0;

  gshare_predictor #(.HIST_BITS(HB), .CTR_BITS(2), .PC_LSB(2)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .Instr_input(Instr_input), .Instr_addr_input(Instr_addr_input),
    .Taken(Taken), .Pred_valid(Pred_valid), .Pred_index(Pred_index), .Ready(Ready),
    .Update_valid(Update_valid), .Update_index(Update_index),
    .Update_taken(Update_taken), .Update_mispredict(Update_mispredict)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit valid;
    bit taken;
    int index;
    bit ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pred_idx_q[$];
  int   checks = 0;
  int   failures = 0;

  int pht_m[DEPTH];
  int spec_m, arch_m, sweep_left, last_uidx;

  localparam logic [31:0] BEQ    = {6'b000100, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] BNE    = {6'b000101, 5'd3, 5'd4, 16'hfff0};
  localparam logic [31:0] BGEZAL = {6'b000001, 5'd3, 5'b10001, 16'h0008};
  localparam logic [31:0] RIBAD  = {6'b000001, 5'd3, 5'b00010, 16'h0008};
  localparam logic [31:0] JMP    = {6'b000010, 26'h0000100};
  localparam logic [31:0] ADD    = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
  localparam logic [31:0] NOP    = 32'h0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit is_branch(input logic [31:0] ins);
    int op;
    int rt;
    op = int'(ins[31:26]);
    rt = int'(ins[20:16]);
    if (op == 1) return (rt == 0) || (rt == 1) || (rt == 16) || (rt == 17);
    return (op >= 4) && (op <= 7);
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    return 32'(((idx ^ spec_m) % DEPTH) * 4);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [1:0]  sel;
    r = $urandom;
    sel = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: r[31:26] = 6'($urandom_range(4, 7));
      1: begin r[31:26] = 6'd1; r[20:16] = {sel[1], 3'b000, sel[0]}; end
      2: r[31:26] = 6'd1;
      3: r[31:26] = 6'($urandom_range(2, 3));
      4: ;
      default: r[31:26] = 6'd0;
    endcase
    return r;
  endfunction

  // Apply one cycle of stimulus; the model predicts what the edge produces.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input bit uv,
                       input int uidx, input bit ut, input bit mis, input bit fl);
    exp_t e;
    int   idx, arch_new;
    bit   restore, pred, tk;
    @(negedge CLK);
    Instr_input = ins;
    Instr_addr_input = pc;
    Update_valid = uv;
    Update_index = HB'(uidx);
    Update_taken = ut;
    Update_mispredict = mis;
    FLUSH = fl;
    if (sweep_left > 0) begin
      pht_m[DEPTH - sweep_left] = INIT;
      sweep_left--;
      e.valid = 0; e.taken = 0; e.index = 0; e.ready = (sweep_left == 0);
    end else begin
      idx = (spec_m ^ int'(pc >> 2)) % DEPTH;
      restore = (uv && mis) || fl;
      pred = is_branch(ins) && !restore;
      tk = pred && (pht_m[idx] >= THRESH);
      arch_new = uv ? (arch_m * 2 + int'(ut)) % DEPTH : arch_m;
      if (uv) begin
        if (ut) pht_m[uidx] = (pht_m[uidx] < CMAX) ? pht_m[uidx] + 1 : CMAX;
        else    pht_m[uidx] = (pht_m[uidx] > 0) ? pht_m[uidx] - 1 : 0;
        last_uidx = uidx;
      end
      if (restore)   spec_m = arch_new;
      else if (pred) spec_m = (spec_m * 2 + int'(tk)) % DEPTH;
      arch_m = arch_new;
      if (pred) pred_idx_q.push_back(idx);
      e.valid = pred; e.taken = tk; e.index = idx; e.ready = 1;
    end
    exp_q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ghr_spec"}, int'(dut.r_ghr_spec), spec_m);
    check({tag, "_ghr_arch"}, int'(dut.r_ghr_arch), arch_m);
    check({tag, "_pht_upd"}, int'(dut.r_pht[last_uidx]), pht_m[last_uidx]);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check({tag, "_rst_taken"}, int'(Taken), 0);
    check({tag, "_rst_pred_valid"}, int'(Pred_valid), 0);
    check({tag, "_rst_pred_index"}, int'(Pred_index), 0);
    check({tag, "_rst_ready"}, int'(Ready), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    spec_m = 0;
    arch_m = 0;
    sweep_left = DEPTH;
    last_uidx = 0;
    pred_idx_q.delete();
  endtask

  task automatic sweep_and_peek(input string tag);
    for (int i = 0; i < DEPTH; i++) drive(BEQ, $urandom, 1, i, 1, 1, 0);
    for (int i = 0; i < DEPTH; i++) check({tag, "_pht_init"}, int'(dut.r_pht[i]), INIT);
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pred_valid", int'(Pred_valid), int'(mon_e.valid));
      check("taken", int'(Taken), int'(mon_e.taken));
      check("ready", int'(Ready), int'(mon_e.ready));
      if (mon_e.valid) check("pred_index", int'(Pred_index), mon_e.index);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit uv, ut, mis, fl;
    int uidx;

    do_reset("initial");
    sweep_and_peek("sweep1");

    // saturation at index 5, lookup after every step
    for (int i = 0; i < 4; i++) begin
      drive(NOP, 0, 1, 5, 1, 0, 0);
      check_state("sat_up");
      drive(BEQ, pc_for(5), 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(NOP, 0, 1, 5, 0, 0, 0);
      check_state("sat_dn");
      drive(BEQ, pc_for(5), 0, 0, 0, 0, 0);
    end
    check("sat_floor", int'(dut.r_pht[5]), 0);

    drive(BGEZAL, $urandom, 0, 0, 0, 0, 0);
    drive(RIBAD, $urandom, 0, 0, 0, 0, 0);
    check_state("dec_regimm");
    drive(JMP, $urandom, 0, 0, 0, 0, 0);
    drive(ADD, $urandom, 0, 0, 0, 0, 0);
    check_state("dec_other");

    // speculative history build-up, then restore by mispredict
    for (int i = 0; i < DEPTH; i++) begin
      drive(NOP, 0, 1, i, 1, 0, 0);
      drive(NOP, 0, 1, i, 1, 0, 0);
    end
    for (int i = 0; i < 4; i++) drive(NOP, 0, 1, 15, 0, 0, 0);
    drive(NOP, 0, 0, 0, 0, 0, 1);
    check("flush_spec", int'(dut.r_ghr_spec), 0);
    for (int i = 0; i < 3; i++) drive(BEQ, 0, 0, 0, 0, 0, 0);
    check("spec_0111", int'(dut.r_ghr_spec), 7);
    drive(NOP, 0, 1, 8, 0, 1, 0);
    check("restore_spec", int'(dut.r_ghr_spec), 0);
    drive(BEQ, 32'h40, 0, 0, 0, 0, 0);
    check("restore_index", int'(Pred_index), 0);

    drive(BNE, $urandom, 0, 0, 0, 0, 1);
    check_state("flush_bne");

    // same-cycle update and lookup on one index: lookup sees old value
    drive(BEQ, pc_for(2), 1, 2, 0, 0, 0);
    check_state("rbw");

    // reset in the middle of normal operation
    for (int i = 0; i < 3; i++) drive(NOP, 0, 1, 3, 1, 0, 0);
    drive(BEQ, pc_for(3), 0, 0, 0, 0, 0);
    check("pre_reset_taken", int'(Taken), 1);
    do_reset("midrun");
    sweep_and_peek("sweep2");
    check("idx3_reinit", int'(dut.r_pht[3]), INIT);

    for (int n = 0; n < 600; n++) begin
      uv = ($urandom_range(0, 1) == 1);
      if (pred_idx_q.size() > 0 && $urandom_range(0, 3) != 0) uidx = pred_idx_q.pop_front();
      else uidx = $urandom_range(0, DEPTH - 1);
      ut = $urandom_range(0, 1) == 1;
      mis = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 19) == 0);
      drive(rand_instr(), $urandom, uv, uidx, ut, mis, fl);
      if (n % 8 == 0) check_state("rand");
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare direction predictor for the fetch stage. It is the successor to the fixed 12-bit global-history predictor. Each conditional branch indexes a pattern history table (PHT) of saturating counters with the XOR of a speculative global history register (GHR) and PC bits. Resolution updates come from execute and carry the index used at prediction. A mispredict or FLUSH restores the speculative history from the architectural history. After reset, an internal sweep FSM initialises the PHT before predictions are enabled.

## Interface
- HIST_BITS, 12, GHR width; PHT depth = 2^HIST_BITS (legal 2..16)
- CTR_BITS, 2, counter width (legal 1..4); MSB = predict taken
- PC_LSB, 2, lowest PC bit used in the index
- INIT_CTR, 2^(CTR_BITS-1)-1, PHT value written by the reset sweep (weakly not-taken)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low
- FLUSH  in  1  synchronous pipeline flush
- Instr_input  in  32  instruction being fetched
- Instr_addr_input  in  32  PC of Instr_input
- Taken  out  1  registered prediction, 1 = branch taken
- Pred_valid  out  1  registered; 1 = Instr_input decoded as a conditional branch and a prediction was made
- Pred_index  out  HIST_BITS  registered PHT index used; pipeline carries it to Update_index
- Ready  out  1  0 during the reset sweep
- Update_valid  in  1  a conditional branch resolved this cycle
- Update_index  in  HIST_BITS  index returned with the branch
- Update_taken  in  1  resolved direction
- Update_mispredict  in  1  resolved direction differs from Taken at fetch

## Operation
- Branch decode: opcode 000001 with rt in {00000, 00001, 10000, 10001}, or opcode 000100/000101/000110/000111. Everything else, including jumps, gives Pred_valid=0, Taken=0.
- Index = ghr_spec XOR Instr_addr_input[PC_LSB+HIST_BITS-1 : PC_LSB].
- Prediction: Taken = pht[index][CTR_BITS-1], Pred_index = index, Pred_valid = 1.
- Speculative history: on each prediction, ghr_spec <= {ghr_spec[HIST_BITS-2:0], predicted bit}.
- Architectural history: on Update_valid, ghr_arch <= {ghr_arch[HIST_BITS-2:0], Update_taken}.
- Counter update, on Update_valid: pht[Update_index] increments if Update_taken, else decrements. It saturates at 2^CTR_BITS-1 and at 0, and never wraps.
- Restore: on Update_valid && Update_mispredict, ghr_spec <= the new ghr_arch value, including this branch's bit.
- FLUSH with no update: ghr_spec <= ghr_arch.
- FSM states:
  - SWEEP: entered on reset. A counter starts at 0 and writes INIT_CTR to one PHT entry per cycle. After the entry at 2^HIST_BITS-1 is written, the state moves to RUN.
  - RUN: normal operation. There is no path back to SWEEP except RESET.
- Priority within a cycle: SWEEP > (mispredict or FLUSH) > prediction.
  - In SWEEP, lookups give Pred_valid=0 and Taken=0, and updates are ignored.
  - In a mispredict or FLUSH cycle, the fetched instruction is wrong-path. Pred_valid and Taken register 0, and no speculative shift occurs.
  - The counter update and ghr_arch shift still happen.
- Same-cycle update and lookup at the same index: the lookup reads the pre-update counter (read-before-write). The write takes effect for the next lookup.

## Timing
- Reset values: Taken 0, Pred_valid 0, Pred_index 0, Ready 0, ghr_spec 0, ghr_arch 0, sweep counter 0, state SWEEP. RESET asserted mid-sweep or mid-run restarts the sweep from entry 0.
- Sweep duration is 2^HIST_BITS cycles after RESET deasserts. Ready registers 1 in the cycle after the last write.
- Lookup latency is 1 cycle: inputs sampled at edge N; Taken, Pred_valid and Pred_index are valid after edge N and held until edge N+1.
- Update latency: the counter and ghr_arch are written at edge N. A lookup sampled at edge N+1 sees them.
- A restored ghr_spec is used by the lookup sampled at edge N+1.

## Test plan
- Sweep (HIST_BITS=4): release RESET and hold Instr_input=BEQ -> Ready=0 and Pred_valid=0 for 16 cycles; Ready=1 from cycle 17. Peek every PHT entry = 01.
- Saturation: 4 updates with index 5, taken -> counter goes 01→10→11→11. Then 4 not-taken updates -> 11→10→01→00→00. Taken after a lookup at index 5 follows the MSB.
- Decode: a BGEZAL (rt=10001) gives Pred_valid=1. An opcode 000001 with rt=00010, a J, or an ADD gives Pred_valid=0 and Taken=0, with ghr_spec unchanged.
- Speculative history and restore: predict 3 branches taken from PHT=11 -> ghr_spec=0111. Then an update with mispredict=1, taken=0 while ghr_arch=0000 -> ghr_spec=0000 next cycle. The next lookup at PC 0x40 uses index 0 XOR 0x0 = 0x0.
- FLUSH during a lookup of BNE -> Pred_valid=0 and Taken=0 that cycle, and ghr_spec=ghr_arch.
- RESET mid-run: train index 3 to 11, pulse RESET -> Taken=0 immediately and Ready=0. After the 16-cycle sweep, index 3 = 01.
